// File: rtl/kws_utterance_controller_pkg.sv
// Shared definitions for the keyword-spotting utterance controller.
//   FRAME_WIDTH  : packed {stop, s, f, amp, f1, f2} feature frame width
//   KW_TIMEOUT   : keyword code reported when no result arrives in time
//   utt_state_e  : controller FSM states
package kws_utterance_controller_pkg;

   // Existing feature field widths from the front-end.
   localparam int STOP_W = 1;
   localparam int S_W    = 1;
   localparam int F_W    = 1;
   localparam int AMP_W  = 8;
   localparam int F1_W   = 8;
   localparam int F2_W   = 8;

   localparam int FRAME_WIDTH = STOP_W + S_W + F_W + AMP_W + F1_W + F2_W;

   localparam logic [3:0] KW_TIMEOUT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_WAIT_KW,
      S_EMIT
   } utt_state_e;

endpackage

// File: rtl/kws_frame_fifo.sv
// Small frame buffer between the feature front-end and the HV generator.
//   clk, rst     : clock, asynchronous active-low reset
//   flush        : synchronous empty (pointers and count zeroed)
//   push/din     : write; accepted when not full, or when full with a pop
//   pop          : read; advances the head (ignored when empty)
//   dout         : current head, driven from storage registers
//   full, empty  : occupancy flags
module kws_frame_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic [AW:0]                 count;
   logic                        do_push, do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/kws_utterance_controller.sv
// Sequences one keyword-spotting utterance: clears the temporal encoder,
// streams FRAMES_PER_UTT feature frames through a buffer to the HV generator,
// waits for the associative-memory keyword (or times out) and emits a result.
//   clk, rst               : clock, asynchronous active-low reset
//   start, abort           : single-cycle control pulses
//   in_valid/in_ready      : upstream frame handshake, in_frame payload
//   fin_valid/fin_ready    : frame handshake to HV generator, fin_frame payload
//   te_clear               : one-cycle temporal-encoder clear
//   kw_valid/kw_ready      : keyword handshake, kw_in payload
//   res_valid/res_ready    : result handshake, res_keyword (4'hF = timeout)
//   busy                   : not idle
module kws_utterance_controller
   import kws_utterance_controller_pkg::*;
#(
   parameter int FRAMES_PER_UTT = 40,
   parameter int FIFO_DEPTH     = 4,
   parameter int RESULT_TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FRAME_WIDTH-1:0] in_frame,
   output logic                   fin_valid,
   input  logic                   fin_ready,
   output logic [FRAME_WIDTH-1:0] fin_frame,
   output logic                   te_clear,
   input  logic                   kw_valid,
   output logic                   kw_ready,
   input  logic [3:0]             kw_in,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [3:0]             res_keyword,
   output logic                   busy
);
   localparam logic [7:0] CNT_N    = 8'(FRAMES_PER_UTT);
   localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_UTT - 1);
   localparam int         TW       = $clog2(RESULT_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(RESULT_TIMEOUT - 1);

   utt_state_e    state, nxt;
   logic [7:0]    acc_cnt, sent_cnt;
   logic [TW-1:0] timer;
   logic          start_latch;
   logic          fifo_full, fifo_empty;
   logic          push, pop, abort_take, clr;

   assign abort_take = abort && (state == S_CLEAR || state == S_STREAM || state == S_WAIT_KW);
   assign clr        = (state == S_CLEAR) || abort_take;

   assign in_ready  = (state == S_STREAM) && !fifo_full && (acc_cnt < CNT_N);
   assign kw_ready  = (state == S_WAIT_KW);
   assign fin_valid = (state == S_STREAM) && !fifo_empty;
   // A frame accepted in the abort cycle is dropped rather than buffered.
   assign push      = in_valid && in_ready && !abort_take;
   assign pop       = fin_valid && fin_ready;

   kws_frame_fifo #(
      .WIDTH (FRAME_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clr),
      .push  (push),
      .pop   (pop),
      .din   (in_frame),
      .dout  (fin_frame),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    if (start) nxt = S_CLEAR;
         S_CLEAR:   nxt = S_STREAM;
         S_STREAM:  if (pop && sent_cnt == CNT_LAST) nxt = S_WAIT_KW;
         S_WAIT_KW: if (kw_valid || timer == T_LAST) nxt = S_EMIT;
         // A start arriving in the handshake cycle counts as already latched.
         S_EMIT:    if (res_ready) nxt = (start_latch || start) ? S_CLEAR : S_IDLE;
         default:   nxt = S_IDLE;
      endcase
      if (abort_take) nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         acc_cnt     <= '0;
         sent_cnt    <= '0;
         timer       <= '0;
         start_latch <= 1'b0;
         te_clear    <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_keyword <= '0;
      end else begin
         state     <= nxt;
         te_clear  <= (nxt == S_CLEAR) || abort_take;
         busy      <= (nxt != S_IDLE);
         res_valid <= (nxt == S_EMIT);

         if (clr) begin
            acc_cnt  <= '0;
            sent_cnt <= '0;
         end else begin
            if (push) acc_cnt  <= acc_cnt + 8'd1;
            if (pop)  sent_cnt <= sent_cnt + 8'd1;
         end

         // Timer idles at zero outside WAIT_KW, so it starts clean on entry.
         if (state == S_WAIT_KW) timer <= timer + 1'b1;
         else                    timer <= '0;

         if (state == S_WAIT_KW && nxt == S_EMIT)
            res_keyword <= kw_valid ? kw_in : KW_TIMEOUT;

         // Latch is consumed on entering CLEAR; extra pulses collapse into it.
         if (abort_take || nxt == S_CLEAR) start_latch <= 1'b0;
         else if (start && state != S_IDLE) start_latch <= 1'b1;
      end
   end

endmodule
